// File: rtl/stack_ctrl.sv
// stack_ctrl: push-down stack controller driving an external async-read,
// sync-write stack memory. Most opcodes finish in the accept cycle; SWAP
// takes a second cycle to write the held value back.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command; single-cycle opcodes execute here
// SWAP2 | second half of SWAP, writes held NOS value at sp-1
module stack_ctrl #(
    parameter int WIDTH = 6,
    parameter int SIZE  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [15:0]      cmd_data,
    output logic [WIDTH-1:0] rd_addr0,
    output logic [WIDTH-1:0] rd_addr1,
    input  logic [15:0]      rd_data0,
    input  logic [15:0]      rd_data1,
    output logic             we,
    output logic [WIDTH-1:0] wr_addr,
    output logic [15:0]      wr_data,
    output logic [15:0]      tos,
    output logic [15:0]      nos,
    output logic [WIDTH:0]   depth,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_DUP     = 3'd3;
    localparam logic [2:0] OP_SWAP    = 3'd4;
    localparam logic [2:0] OP_OVER    = 3'd5;
    localparam logic [2:0] OP_REPLACE = 3'd6;
    localparam logic [2:0] OP_CLEAR   = 3'd7;

    localparam logic [WIDTH:0]   FULL_DEPTH = (WIDTH+1)'(SIZE);
    localparam logic [WIDTH:0]   D_ONE      = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   D_TWO      = (WIDTH+1)'(2);
    localparam logic [WIDTH-1:0] P_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] P_TWO      = WIDTH'(2);

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sp;
    logic [15:0]      hold;

    logic             accept;
    logic             is_full;
    logic             has_one;
    logic             has_two;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr_c;
    logic [15:0]      wr_data_c;
    logic [WIDTH:0]   depth_nxt;
    logic [WIDTH-1:0] sp_nxt;
    logic             set_ovf;
    logic             set_unf;
    logic             do_clear;
    logic             go_swap;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready && !rst;
    assign rd_addr0  = sp - P_ONE;
    assign rd_addr1  = sp - P_TWO;
    assign tos       = rd_data0;
    assign nos       = rd_data1;

    assign is_full = (depth == FULL_DEPTH);
    assign has_one = (depth >= D_ONE);
    assign has_two = (depth >= D_TWO);

    // Decode the accepted command (or the SWAP2 write-back) into the write
    // port, the next pointer/depth and error-flag requests.
    always_comb begin
        wr_en     = 1'b0;
        wr_addr_c = sp;
        wr_data_c = cmd_data;
        depth_nxt = depth;
        sp_nxt    = sp;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        do_clear  = 1'b0;
        go_swap   = 1'b0;
        if (accept) begin
            case (cmd_op)
                OP_PUSH: begin
                    if (!is_full) begin
                        wr_en     = 1'b1;
                        wr_data_c = cmd_data;
                        depth_nxt = depth + D_ONE;
                        sp_nxt    = sp + P_ONE;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end
                OP_POP: begin
                    if (has_one) begin
                        depth_nxt = depth - D_ONE;
                        sp_nxt    = sp - P_ONE;
                    end else begin
                        set_unf = 1'b1;
                    end
                end
                OP_DUP: begin
                    if (!has_one) begin
                        set_unf = 1'b1;
                    end else if (is_full) begin
                        set_ovf = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        wr_data_c = rd_data0;
                        depth_nxt = depth + D_ONE;
                        sp_nxt    = sp + P_ONE;
                    end
                end
                OP_OVER: begin
                    if (!has_two) begin
                        set_unf = 1'b1;
                    end else if (is_full) begin
                        set_ovf = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        wr_data_c = rd_data1;
                        depth_nxt = depth + D_ONE;
                        sp_nxt    = sp + P_ONE;
                    end
                end
                OP_REPLACE: begin
                    if (has_two) begin
                        wr_en     = 1'b1;
                        wr_addr_c = sp - P_TWO;
                        wr_data_c = cmd_data;
                        depth_nxt = depth - D_ONE;
                        sp_nxt    = sp - P_ONE;
                    end else begin
                        set_unf = 1'b1;
                    end
                end
                OP_SWAP: begin
                    if (has_two) begin
                        wr_en     = 1'b1;
                        wr_addr_c = sp - P_TWO;
                        wr_data_c = rd_data0;
                        go_swap   = 1'b1;
                    end else begin
                        set_unf = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    do_clear  = 1'b1;
                    depth_nxt = '0;
                    sp_nxt    = '0;
                end
                default: begin
                end
            endcase
        end else if (state == SWAP2 && !rst) begin
            wr_en     = 1'b1;
            wr_addr_c = sp - P_ONE;
            wr_data_c = hold;
        end
    end

    assign we      = wr_en;
    assign wr_addr = wr_addr_c;
    assign wr_data = wr_data_c;

    // Controller FSM: pointer, depth, sticky error flags and SWAP hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sp            <= '0;
            depth         <= '0;
            hold          <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sp    <= sp_nxt;
                        depth <= depth_nxt;
                        if (do_clear) begin
                            err_overflow  <= 1'b0;
                            err_underflow <= 1'b0;
                        end else begin
                            if (set_ovf) err_overflow  <= 1'b1;
                            if (set_unf) err_underflow <= 1'b1;
                        end
                        if (go_swap) begin
                            hold  <= rd_data1;
                            state <= SWAP2;
                        end
                    end
                end
                SWAP2: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed bench for stack_ctrl with a behavioral stack memory.
module tb_stack_ctrl;

    localparam int WIDTH = 6;
    localparam int SIZE  = 64;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_DUP     = 3'd3;
    localparam logic [2:0] OP_SWAP    = 3'd4;
    localparam logic [2:0] OP_OVER    = 3'd5;
    localparam logic [2:0] OP_REPLACE = 3'd6;
    localparam logic [2:0] OP_CLEAR   = 3'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [15:0]      cmd_data;
    logic [WIDTH-1:0] rd_addr0, rd_addr1;
    logic [15:0]      rd_data0, rd_data1;
    logic             we;
    logic [WIDTH-1:0] wr_addr;
    logic [15:0]      wr_data;
    logic [15:0]      tos, nos;
    logic [WIDTH:0]   depth;
    logic             err_overflow, err_underflow;

    logic [15:0]      mem [0:SIZE-1];
    int               wr_cnt;
    logic [WIDTH-1:0] last_wr_addr;
    logic [15:0]      last_wr_data;
    int               n_chk;
    int               n_pass;
    int               snap;

    stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .rd_addr0      (rd_addr0),
        .rd_addr1      (rd_addr1),
        .rd_data0      (rd_data0),
        .rd_data1      (rd_data1),
        .we            (we),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .tos           (tos),
        .nos           (nos),
        .depth         (depth),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    assign rd_data0 = mem[rd_addr0];
    assign rd_data1 = mem[rd_addr1];

    // Stack memory write port plus a record of every committed write.
    always @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= wr_addr;
            last_wr_data <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; presents one command for exactly one posedge.
    task automatic issue(input logic [2:0] op, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 16'h0;
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = 16'h0;
        wr_cnt = 0; last_wr_addr = '0; last_wr_data = '0;
        n_chk = 0; n_pass = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 16'h0;
        // Command present during reset must be ignored.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 16'hDEAD;
        chk("we_in_rst", we, 0);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 16'h0;
        rst = 1'b0;
        chk("rst_depth", depth, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_unf", err_underflow, 0);
        chk("rst_nowr", wr_cnt, 0);

        // Two pushes back to back.
        issue(OP_PUSH, 16'h1111);
        issue(OP_PUSH, 16'h2222);
        chk("p2_depth", depth, 2);
        chk("p2_tos", tos, 16'h2222);
        chk("p2_nos", nos, 16'h1111);
        chk("p2_errs", {err_overflow, err_underflow}, 0);

        // SWAP: ready low one cycle, then swapped; then DUP.
        issue(OP_SWAP, 16'h0);
        chk("swap_busy", cmd_ready, 0);
        @(negedge clk);
        chk("swap_ready", cmd_ready, 1);
        chk("swap_tos", tos, 16'h1111);
        chk("swap_nos", nos, 16'h2222);
        chk("swap_depth", depth, 2);
        issue(OP_DUP, 16'h0);
        chk("dup_depth", depth, 3);
        chk("dup_tos", tos, 16'h1111);
        chk("dup_nos", nos, 16'h1111);

        // Underflow from empty, stickiness, and CLEAR.
        issue(OP_CLEAR, 16'h0);
        chk("clr_depth", depth, 0);
        snap = wr_cnt;
        issue(OP_POP, 16'h0);
        chk("pop_unf", err_underflow, 1);
        chk("pop_depth", depth, 0);
        chk("pop_nowr", wr_cnt, snap);
        issue(OP_SWAP, 16'h0);
        chk("swap_empty_ready", cmd_ready, 1);
        chk("swap_empty_nowr", wr_cnt, snap);
        issue(OP_PUSH, 16'h0005);
        chk("p5_depth", depth, 1);
        chk("p5_unf_sticky", err_underflow, 1);
        chk("p5_tos", tos, 16'h0005);
        issue(OP_CLEAR, 16'h0);
        chk("clr2_depth", depth, 0);
        chk("clr2_unf", err_underflow, 0);

        // Fill to full, overflow, drain.
        for (int i = 0; i < SIZE; i++) issue(OP_PUSH, 16'(i));
        chk("full_depth", depth, 64);
        chk("full_tos", tos, 16'h003F);
        chk("full_nos", nos, 16'h003E);
        snap = wr_cnt;
        issue(OP_PUSH, 16'hBEEF);
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_depth", depth, 64);
        chk("ovf_nowr", wr_cnt, snap);
        chk("ovf_tos", tos, 16'h003F);
        chk("ovf_unf", err_underflow, 0);
        issue(OP_DUP, 16'h0);
        chk("dup_full_depth", depth, 64);
        chk("dup_full_nowr", wr_cnt, snap);
        for (int i = 0; i < SIZE; i++) issue(OP_POP, 16'h0);
        chk("drain_depth", depth, 0);
        chk("drain_ovf_sticky", err_overflow, 1);
        chk("drain_unf", err_underflow, 0);
        issue(OP_CLEAR, 16'h0);
        chk("clr3_ovf", err_overflow, 0);

        // REPLACE pops two, pushes one at sp-2.
        issue(OP_PUSH, 16'h0003);
        issue(OP_PUSH, 16'h0004);
        issue(OP_REPLACE, 16'h0007);
        chk("repl_depth", depth, 1);
        chk("repl_tos", tos, 16'h0007);
        chk("repl_addr", last_wr_addr, 0);
        chk("repl_data", last_wr_data, 16'h0007);
        snap = wr_cnt;
        issue(OP_REPLACE, 16'h0009);
        chk("repl1_unf", err_underflow, 1);
        chk("repl1_depth", depth, 1);
        chk("repl1_nowr", wr_cnt, snap);
        issue(OP_CLEAR, 16'h0);

        // OVER and NOP.
        issue(OP_PUSH, 16'h0007);
        issue(OP_PUSH, 16'h0009);
        issue(OP_OVER, 16'h0);
        chk("over_depth", depth, 3);
        chk("over_tos", tos, 16'h0007);
        chk("over_nos", nos, 16'h0009);
        snap = wr_cnt;
        issue(OP_NOP, 16'h1234);
        chk("nop_depth", depth, 3);
        chk("nop_nowr", wr_cnt, snap);
        chk("nop_tos", tos, 16'h0007);

        // Reset during SWAP2 suppresses the write-back.
        issue(OP_CLEAR, 16'h0);
        issue(OP_PUSH, 16'h000A);
        issue(OP_PUSH, 16'h000B);
        issue(OP_SWAP, 16'h0);
        chk("swaprst_busy", cmd_ready, 0);
        chk("swaprst_wr1", last_wr_addr, 0);
        snap = wr_cnt;
        rst = 1'b1;
        #1;
        chk("swaprst_we", we, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("swaprst_nowr", wr_cnt, snap);
        chk("swaprst_depth", depth, 0);
        chk("swaprst_ready", cmd_ready, 1);
        issue(OP_PUSH, 16'h0042);
        chk("after_rst_depth", depth, 1);
        chk("after_rst_tos", tos, 16'h0042);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
